instr_fetch_ctrl: RTL and testbench
===================================

Name: instr_fetch_ctrl

Overview:
Fetch sequencer for the single-cycle CPU's combinational, read-only instruction memory.
- Owns the program counter and drives the memory address.
- Registers each returned 32-bit instruction into a one-entry output slot with a valid/ready handshake toward decode.
- Supports run/stop, single-step debug mode, branch/jump redirect and automatic halt at end of program.

Parameters:
WIDTH, 8, instruction address width (matches instruction memory address port)
N_INSTR, 7, number of valid program words; legal range 1..2^WIDTH
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
run  in  1  level; 1 = fetching enabled
step_mode  in  1  level; 1 = one fetch per step pulse
step  in  1  single-cycle pulse; permits one fetch in step_mode
imem_addr  out  WIDTH  address to instruction memory; always equals pc
imem_rd  in  32  instruction word from memory, combinational from imem_addr
instr  out  32  registered instruction
instr_pc  out  WIDTH  address instr was fetched from
instr_valid  out  1  output slot holds an instruction
instr_ready  in  1  decode accepts instr this cycle
redirect_valid  in  1  branch/jump taken; flush and load new pc
redirect_addr  in  WIDTH  target address
halted  out  1  state == HALT
fetch_state  out  2  current FSM state, for debug LEDs
retired_cnt  out  16  count of accepted handshakes, saturating at 16'hFFFF

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, instr=32'h0, instr_pc=0, instr_valid=0, retired_cnt=0, state=IDLE, halted=0.
- States: IDLE=0, FETCH=1, HALT=2.
- Slot free means: instr_valid==0, or (instr_valid && instr_ready).
- Fetch enable:
  - fetch_en = state==FETCH && slot free && pc<N_INSTR && (!step_mode || step).
  - On fetch_en: instr<=imem_rd, instr_pc<=pc, instr_valid<=1, pc<=pc+1.
  - Latency: the address presented in cycle t yields instr_valid in cycle t+1.
  - Throughput: 1 instruction/cycle when ready is held high and step_mode=0.
- Handshake:
  - An accepted word without a new fetch clears instr_valid.
  - instr and instr_pc are held stable while valid && !ready.
  - retired_cnt increments on every valid&&ready, including a handshake in the same cycle as a redirect.
- IDLE -> FETCH when run=1.
- FETCH -> IDLE when run=0: no new fetch in that cycle; a pending slot stays valid until accepted.
- FETCH -> HALT when pc>=N_INSTR and slot free (last word drained or accepted that cycle). halted=1 in HALT.
- HALT -> FETCH only on redirect_valid with redirect_addr<N_INSTR. Other inputs are ignored.
- Redirect (highest priority, any state):
  - pc<=redirect_addr and instr_valid<=0 (flush); no fetch in that cycle.
  - Fetching resumes from the new pc the next cycle if state is FETCH.
  - In IDLE, only pc is updated.
  - redirect_addr>=N_INSTR: pc is loaded, then FETCH->HALT on the next cycle.
- step pulse ignored when step_mode=0, when the slot is not free, or when state!=FETCH; step pulses are not queued.
- pc arithmetic is WIDTH bits unsigned. No wrap occurs because the halt check precedes the increment. If N_INSTR==2^WIDTH, halt is detected via a carry bit (compare with WIDTH+1 bits).
- Async reset mid-stream discards the slot immediately; no partial word is visible.

Decomposition:
- Package fetch_pkg:
  - typedef enum logic[1:0] {IDLE, FETCH, HALT} fetch_state_t
  - INSTR_W=32
  - CNT_W=16
  - NOP_WORD=32'h0
- Sub-module fetch_slot: one-entry valid/ready output register holding instr/instr_pc, with load, flush and accept inputs. The FSM, pc and counter stay in the top.

Test Plan:
- Free run, 7-word program, word0=32'h20010003, word1=32'h20020009, ready=1, run=1:
  - instr_valid rises 2 cycles after run (1 cycle IDLE->FETCH, 1 cycle latency).
  - instr_pc sequence is 0..6.
  - halted=1 one cycle after pc=6 is accepted.
  - retired_cnt=7.
- Backpressure: hold ready=0 for 3 cycles while instr_pc=2:
  - instr and instr_pc stay stable and pc stays 3.
  - After ready=1, instr_pc=3 follows with no loss or duplication.
- Redirect at instr_pc=4 with redirect_addr=1, ready=1:
  - The word at pc=4 is counted (retired_cnt=5) and then flushed.
  - The next valid word has instr_pc=1 and equals 32'h20020009.
- Step mode (step_mode=1), pulses 5 cycles apart:
  - Exactly one instruction per pulse.
  - A step pulse while the slot is full (ready=0) is ignored.
- HALT then redirect_addr=0: returns to FETCH and fetches word0 again. redirect_addr=7 from HALT: stays halted.
- Assert rst_n=0 mid-fetch at instr_pc=3: outputs clear immediately. After release with run=1, fetching restarts at pc=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
//   fetch_state_t : FSM encoding, also exported on the debug port
//   INSTR_W       : instruction word width
//   CNT_W         : retired-instruction counter width
//   NOP_WORD      : value the output slot holds after reset
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  localparam int          INSTR_W  = 32;
  localparam int          CNT_W    = 16;
  localparam logic [31:0] NOP_WORD = 32'h0;

endpackage

// File: rtl/fetch_slot.sv
// One-entry valid/ready output register between fetch and decode.
//   clk, rst_n : clock, async active-low reset
//   i_load     : capture i_instr/i_pc and mark the slot valid
//   i_flush    : drop the held word (wins over load)
//   i_ready    : downstream accepts the held word this cycle
//   i_instr    : instruction word to capture
//   i_pc       : address the word was fetched from
//   o_valid    : slot holds a word
//   o_instr    : held word (stable while valid and not accepted)
//   o_pc       : address of the held word
//   o_accept   : handshake completes this cycle (valid && ready)
//   o_free     : slot can take a new word this cycle
module fetch_slot
  import fetch_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_flush,
  input  logic               i_ready,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [WIDTH-1:0]   i_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [WIDTH-1:0]   o_pc,
  output logic               o_accept,
  output logic               o_free
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [WIDTH-1:0]   r_pc;

  // NOTE: the payload registers are reset too, so nothing stale from before
  // reset can ever appear on instr/instr_pc, even while valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= NOP_WORD;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      // NOTE: non-blocking assignments keep every register in this block
      // updating from pre-edge values, independent of statement order.
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (o_accept) begin
      r_valid <= 1'b0;
    end
  end

  assign o_accept = r_valid && i_ready;
  assign o_free   = !r_valid || i_ready;
  assign o_valid  = r_valid;
  assign o_instr  = r_instr;
  assign o_pc     = r_pc;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer for a combinational, read-only instruction memory.
// Owns the pc, fills a one-entry output slot and stops at end of program.
//   clk, rst_n           : clock, async active-low reset
//   run                  : level, fetching enabled
//   step_mode, step      : when step_mode=1, one fetch per step pulse
//   imem_addr / imem_rd  : instruction memory address / returned word
//   instr, instr_pc      : registered word and the address it came from
//   instr_valid/ready    : handshake toward decode
//   redirect_valid/addr  : branch/jump taken; flush and reload pc
//   halted, fetch_state  : FSM status for debug
//   retired_cnt          : accepted handshakes, saturating
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int N_INSTR  = 7,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               step_mode,
  input  logic               step,
  output logic [WIDTH-1:0]   imem_addr,
  input  logic [INSTR_W-1:0] imem_rd,
  output logic [INSTR_W-1:0] instr,
  output logic [WIDTH-1:0]   instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [WIDTH-1:0]   redirect_addr,
  output logic               halted,
  output logic [1:0]         fetch_state,
  output logic [CNT_W-1:0]   retired_cnt
);

  // pc carries one extra bit so a program filling the whole address space
  // still reaches the end-of-program condition instead of wrapping to 0.
  localparam logic [WIDTH:0] N_LIM    = (WIDTH + 1)'(N_INSTR);
  localparam logic [WIDTH:0] PC_RESET = (WIDTH + 1)'(RESET_PC);

  fetch_state_t     r_state, w_next_state;
  logic [WIDTH:0]   r_pc;
  logic [CNT_W-1:0] r_cnt;

  logic w_fetch_en, w_flush, w_accept, w_slot_free;
  logic w_pc_in_prog, w_redir_in_prog;

  assign w_pc_in_prog    = r_pc < N_LIM;
  assign w_redir_in_prog = {1'b0, redirect_addr} < N_LIM;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every output of this block is defaulted first, so no path through
  // the case can leave a signal unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_fetch_en   = 1'b0;
    w_flush      = 1'b0;
    unique case (r_state)
      // A redirect in IDLE only moves the pc; it does not start fetching.
      IDLE: if (!redirect_valid && run) w_next_state = FETCH;
      FETCH: begin
        if (redirect_valid) begin
          w_flush = 1'b1;
          if (!run) w_next_state = IDLE;
        end else if (!run) begin
          w_next_state = IDLE;
        end else if (w_slot_free) begin
          // Halt only once the slot drains, so the last word is delivered.
          if (!w_pc_in_prog)             w_next_state = HALT;
          else if (!step_mode || step)   w_fetch_en   = 1'b1;
        end
      end
      HALT: begin
        if (redirect_valid) begin
          w_flush = 1'b1;
          if (w_redir_in_prog) w_next_state = FETCH;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_pc <= PC_RESET;
    else if (redirect_valid) r_pc <= {1'b0, redirect_addr};
    else if (w_fetch_en)     r_pc <= r_pc + 1'b1;
  end

  // Counts every handshake, including one coinciding with a redirect flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_cnt <= '0;
    else if (w_accept && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end

  fetch_slot #(.WIDTH(WIDTH)) u_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_fetch_en),
    .i_flush  (w_flush),
    .i_ready  (instr_ready),
    .i_instr  (imem_rd),
    .i_pc     (r_pc[WIDTH-1:0]),
    .o_valid  (instr_valid),
    .o_instr  (instr),
    .o_pc     (instr_pc),
    .o_accept (w_accept),
    .o_free   (w_slot_free)
  );

  assign imem_addr   = r_pc[WIDTH-1:0];
  assign halted      = (r_state == HALT);
  assign fetch_state = r_state;
  assign retired_cnt = r_cnt;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;

  localparam int N = 7;
  localparam int S_IDLE = 0, S_FETCH = 1, S_HALT = 2;

  logic        clk = 1'b0;
  logic        rst_n, run, step_mode, step, instr_ready, redirect_valid;
  logic [7:0]  redirect_addr, imem_addr, instr_pc;
  logic [31:0] imem_rd, instr;
  logic        instr_valid, halted;
  logic [1:0]  fetch_state;
  logic [15:0] retired_cnt;

  logic [31:0] mem [256];
  assign imem_rd = mem[imem_addr];

  instr_fetch_ctrl #(.WIDTH(8), .N_INSTR(N), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step_mode(step_mode), .step(step),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .halted(halted), .fetch_state(fetch_state), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integers following the fetch rules.
  int          m_state, m_pc, m_ipc, m_cnt;
  bit          m_valid;
  logic [31:0] m_instr;

  task automatic model_reset();
    m_state = S_IDLE; m_pc = 0; m_ipc = 0; m_cnt = 0; m_valid = 0; m_instr = 32'h0;
  endtask

  // Advance one clock: predict from current inputs, clock, compare everything.
  task automatic tick();
    int n_state, n_pc, n_ipc, n_cnt;
    bit n_valid, acc, free;
    logic [31:0] n_instr;
    acc = m_valid && instr_ready;
    free = !m_valid || instr_ready;
    n_state = m_state; n_pc = m_pc; n_ipc = m_ipc; n_instr = m_instr;
    n_valid = m_valid && !acc;
    n_cnt = (acc && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
    if (redirect_valid) begin
      n_pc = int'(redirect_addr);
      if (m_state != S_IDLE) n_valid = 0;
      if (m_state == S_HALT && int'(redirect_addr) < N) n_state = S_FETCH;
      else if (m_state == S_FETCH && !run) n_state = S_IDLE;
    end else if (m_state == S_IDLE) begin
      if (run) n_state = S_FETCH;
    end else if (m_state == S_FETCH) begin
      if (!run) n_state = S_IDLE;
      else if (free && m_pc >= N) n_state = S_HALT;
      else if (free && (!step_mode || step)) begin
        n_valid = 1; n_ipc = m_pc; n_instr = mem[m_pc]; n_pc = m_pc + 1;
      end
    end
    @(posedge clk); #1;
    m_state = n_state; m_pc = n_pc; m_ipc = n_ipc; m_instr = n_instr;
    m_valid = n_valid; m_cnt = n_cnt;
    check("m_state", fetch_state, m_state);
    check("m_halted", halted, m_state == S_HALT);
    check("m_addr", imem_addr, m_pc);
    check("m_valid", instr_valid, m_valid);
    check("m_ipc", instr_pc, m_ipc);
    check("m_instr", instr, m_instr);
    check("m_cnt", retired_cnt, m_cnt);
  endtask

  task automatic idle_inputs();
    run = 0; step_mode = 0; step = 0; instr_ready = 1;
    redirect_valid = 0; redirect_addr = 0;
  endtask

  // Async reset: outputs must clear without waiting for a clock edge.
  task automatic apply_reset();
    rst_n = 0;
    #1;
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_ipc", instr_pc, 0);
    check("rst_cnt", retired_cnt, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_state", fetch_state, S_IDLE);
    check("rst_halted", halted, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic wait_ipc(input int target);
    for (int i = 0; i < 30 && !(instr_valid && int'(instr_pc) == target); i++) tick();
    check("reach_ipc", instr_valid ? 32'(instr_pc) : 32'hFFFF_FFFF, target);
  endtask

  typedef struct {
    logic       run;
    logic       ready;
    logic [1:0] exp_state;
    logic       exp_valid;
    logic [7:0] exp_ipc;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_seen;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
    mem[0] = 32'h2001_0003;
    mem[1] = 32'h2002_0009;
    idle_inputs();
    rst_n = 0;
    apply_reset();

    // Free run: table of {run, ready} -> {state, valid, instr_pc, retired}.
    vecs[0]  = '{0, 1, S_IDLE,  0, 0, 0};
    vecs[1]  = '{1, 1, S_FETCH, 0, 0, 0};
    vecs[2]  = '{1, 1, S_FETCH, 1, 0, 0};
    vecs[3]  = '{1, 1, S_FETCH, 1, 1, 1};
    vecs[4]  = '{1, 1, S_FETCH, 1, 2, 2};
    vecs[5]  = '{1, 1, S_FETCH, 1, 3, 3};
    vecs[6]  = '{1, 1, S_FETCH, 1, 4, 4};
    vecs[7]  = '{1, 1, S_FETCH, 1, 5, 5};
    vecs[8]  = '{1, 1, S_FETCH, 1, 6, 6};
    vecs[9]  = '{1, 1, S_HALT,  0, 6, 7};
    vecs[10] = '{0, 1, S_HALT,  0, 6, 7};
    for (int i = 0; i < 11; i++) begin
      run = vecs[i].run; instr_ready = vecs[i].ready;
      tick();
      check($sformatf("v%0d_state", i), fetch_state, vecs[i].exp_state);
      check($sformatf("v%0d_halted", i), halted, vecs[i].exp_state == S_HALT);
      check($sformatf("v%0d_valid", i), instr_valid, vecs[i].exp_valid);
      check($sformatf("v%0d_cnt", i), retired_cnt, vecs[i].exp_cnt);
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d_ipc", i), instr_pc, vecs[i].exp_ipc);
        check($sformatf("v%0d_instr", i), instr, mem[vecs[i].exp_ipc]);
      end
    end

    // HALT: out-of-program redirect is ignored, redirect to 0 restarts.
    redirect_valid = 1; redirect_addr = 7;
    tick();
    check("halt_r7", halted, 1);
    redirect_addr = 0; run = 1;
    tick();
    redirect_valid = 0;
    check("halt_r0_state", fetch_state, S_FETCH);
    tick();
    check("halt_r0_valid", instr_valid, 1);
    check("halt_r0_ipc", instr_pc, 0);
    check("halt_r0_instr", instr, 32'h2001_0003);

    // Backpressure at instr_pc=2.
    idle_inputs(); apply_reset();
    run = 1;
    wait_ipc(2);
    instr_ready = 0;
    repeat (3) begin
      tick();
      check("bp_ipc", instr_pc, 2);
      check("bp_instr", instr, mem[2]);
      check("bp_pc", imem_addr, 3);
    end
    instr_ready = 1;
    tick();
    check("bp_next_ipc", instr_pc, 3);
    tick();
    check("bp_next2_ipc", instr_pc, 4);

    // Redirect at instr_pc=4 to address 1.
    idle_inputs(); apply_reset();
    run = 1;
    wait_ipc(4);
    redirect_valid = 1; redirect_addr = 1;
    tick();
    redirect_valid = 0;
    check("rd_cnt", retired_cnt, 5);
    check("rd_flush", instr_valid, 0);
    tick();
    check("rd_valid", instr_valid, 1);
    check("rd_ipc", instr_pc, 1);
    check("rd_instr", instr, 32'h2002_0009);

    // Step mode: one fetch per pulse, pulses ignored while slot is full.
    idle_inputs(); apply_reset();
    run = 1; step_mode = 1;
    tick(); tick();
    check("st_nofetch", instr_valid, 0);
    n_seen = 0;
    for (int p = 0; p < 3; p++) begin
      step = 1; tick(); step = 0;
      if (instr_valid) n_seen++;
      repeat (4) begin tick(); if (instr_valid) n_seen++; end
    end
    check("st_count", n_seen, 3);
    instr_ready = 0;
    step = 1; tick(); step = 0;
    tick();
    step = 1; tick(); step = 0;
    check("st_full_ipc", instr_pc, 3);
    check("st_full_pc", imem_addr, 4);
    instr_ready = 1;
    tick();
    check("st_drain_valid", instr_valid, 0);
    check("st_drain_cnt", retired_cnt, 4);

    // Async reset in the middle of a stream, then restart from pc 0.
    idle_inputs(); apply_reset();
    run = 1;
    wait_ipc(3);
    #2;
    apply_reset();
    tick(); tick();
    check("rr_valid", instr_valid, 1);
    check("rr_ipc", instr_pc, 0);

    // Randomized stimulus against the model.
    idle_inputs(); apply_reset();
    for (int c = 0; c < 500; c++) begin
      run            = ($urandom_range(9) != 0);
      step_mode      = ($urandom_range(2) == 0);
      step           = $urandom_range(1);
      instr_ready    = ($urandom_range(9) < 7);
      redirect_valid = ($urandom_range(15) == 0);
      redirect_addr  = 8'($urandom_range(9));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
